// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the program counter, issues word
// reads over a req/ack handshake, buffers returned words in a small prefetch
// FIFO and presents the head to the decoder. Taken branches flush the buffer
// and redirect fetch; a read already in flight is drained and its data dropped.
// Build option FETCH_PREFETCH_EN: two-entry prefetch buffer (back-to-back
// requests). Left undefined, the buffer holds a single entry.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        PCSource,
    input  logic [23:0] inm,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic [1:0]  dbg_state
);

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [1:0] DEPTH_CNT = 2'(DEPTH);

    // Memory handshake: imem_req rises together with a valid imem_addr and both
    // stay constant until imem_ack is seen high at a clock edge; that edge
    // completes the read and imem_rdata is captured in the same cycle. imem_ack
    // is ignored whenever imem_req is low.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_imem_req;
    logic [31:0] r_imem_addr;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_last_pc;
    logic [31:0] r_buf_pc   [DEPTH];
    logic [31:0] r_buf_word [DEPTH];
    logic [1:0]  r_count;

    logic        w_ack;
    logic        w_push;
    logic        w_pop;
    logic        w_space;
    logic [1:0]  w_occ_next;
    logic [1:0]  w_wr_idx;
    logic [31:0] w_target;
    logic [31:0] w_next_pc;

    // A redirect overrides both push and pop in the same cycle.
    assign w_ack      = imem_ack & r_imem_req;
    assign w_push     = (r_state == S_WAIT) & w_ack & ~PCSource;
    assign w_pop      = instr_valid & ~stall & ~PCSource;
    assign w_occ_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
    assign w_space    = (w_occ_next < DEPTH_CNT);
    assign w_wr_idx   = r_count - {1'b0, w_pop};
    assign w_next_pc  = r_fetch_pc + 32'd4;
    assign w_target   = r_last_pc + 32'd8 + {{6{inm[23]}}, inm, 2'b00};

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_imem_addr;
    assign instruction = r_buf_word[0];
    assign pc_out      = r_buf_pc[0];
    assign instr_valid = (r_count != 2'd0);
    assign dbg_state   = r_state;

    // Fetch FSM: request sequencing, fetch pc and redirect/drain handling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_imem_req  <= 1'b0;
            r_imem_addr <= 32'd0;
            r_fetch_pc  <= RESET_PC;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (PCSource) begin
                        r_fetch_pc  <= w_target;
                        r_imem_addr <= w_target;
                        r_imem_req  <= 1'b1;
                        r_state     <= S_WAIT;
                    end else if (w_space) begin
                        r_imem_addr <= r_fetch_pc;
                        r_imem_req  <= 1'b1;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (PCSource) begin
                        r_fetch_pc <= w_target;
                        if (w_ack) begin
                            // Returned word belongs to the old path: drop it.
                            r_imem_addr <= w_target;
                        end else begin
                            // Request must stay stable until acked.
                            r_state <= S_DRAIN;
                        end
                    end else if (w_ack) begin
                        r_fetch_pc <= w_next_pc;
                        if (w_space) begin
                            r_imem_addr <= w_next_pc;
                        end else begin
                            r_imem_req <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (PCSource) begin
                        r_fetch_pc <= w_target;
                    end
                    if (w_ack) begin
                        r_imem_addr <= PCSource ? w_target : r_fetch_pc;
                        r_state     <= S_WAIT;
                    end
                end
                default: begin
                    r_imem_req <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    // Prefetch buffer: shift FIFO with the head at index 0, plus last popped pc.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= 2'd0;
            r_last_pc <= RESET_PC - 32'd8;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_pc[i]   <= 32'd0;
                r_buf_word[i] <= 32'd0;
            end
        end else if (PCSource) begin
            r_count <= 2'd0;
        end else begin
            if (w_pop) begin
                r_last_pc <= r_buf_pc[0];
                for (int i = 0; i < DEPTH - 1; i++) begin
                    r_buf_pc[i]   <= r_buf_pc[i+1];
                    r_buf_word[i] <= r_buf_word[i+1];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (w_wr_idx == 2'(i))) begin
                    r_buf_pc[i]   <= r_fetch_pc;
                    r_buf_word[i] <= imem_rdata;
                end
            end
            r_count <= w_occ_next;
        end
    end

endmodule
